sar_avg_seq: RTL and testbench

Conversion sequencer and oversampling averager downstream of the SAR control logic. On a start request it holds the SAR enable high, collects 2^osr 8-bit conversion results, and averages them with a right shift. It presents the average on a valid/ready output port, either once or continuously. It sits between the SAR control logic and the digital readout/register interface.

---
 rtl/sar_avg_pkg.sv | 25 ++
 rtl/sar_avg_seq_if.sv | 18 +
 rtl/sar_avg_shift.sv | 39 +++
 rtl/sar_avg_seq.sv | 138 +++++++++++++
 tb/tb_sar_avg_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_avg_pkg.sv
// sar_avg_pkg
// Shared types and sizing for the SAR conversion sequencer / averager.
//   sar_state_e : sequencer states (IDLE, RUN, OUT)
//   DW_DEF      : default SAR result width
//   OSR_W_DEF   : default width of the oversampling-ratio field
//   acc_w()     : accumulator width able to hold 2^(2^osr_w - 1) full-scale
//                 samples without overflow
package sar_avg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } sar_state_e;

    localparam int DW_DEF    = 8;
    localparam int OSR_W_DEF = 3;

    // Largest burst is 2^(2^osr_w - 1) samples, so the sum needs that many
    // extra bits on top of the sample width.
    function automatic int acc_w(input int dw, input int osr_w);
        return dw + (1 << osr_w) - 1;
    endfunction

endpackage

// File: rtl/sar_avg_seq_if.sv
// sar_avg_seq_if
// Valid/ready output stream carrying the averaged conversion result.
//   out_valid : average available (producer -> consumer)
//   out_data  : averaged result, DW bits (producer -> consumer)
//   out_ready : consumer accepts (consumer -> producer)
// Modports: master = averager side, slave = readout side.
interface sar_avg_seq_if
    import sar_avg_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/sar_avg_shift.sv
// sar_avg_shift
// Combinational divide-by-2^osr of the accumulated sum.
//   sum_i : ACC_W-bit sum of 2^osr_i samples
//   osr_i : log2 of the sample count
//   avg_o : DW-bit average
// Build option: define SAR_AVG_ROUND_EN for round-half-up; otherwise the
// average is truncated. osr_i = 0 passes the sum through in both builds.
module sar_avg_shift
    import sar_avg_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OSR_W = OSR_W_DEF,
    parameter int ACC_W = acc_w(DW_DEF, OSR_W_DEF)
) (
    input  logic [ACC_W-1:0] sum_i,
    input  logic [OSR_W-1:0] osr_i,
    output logic [DW-1:0]    avg_o
);
    // One spare bit so adding the rounding bias can never wrap.
    logic [ACC_W:0] rounded;

`ifdef SAR_AVG_ROUND_EN
    always_comb begin
        rounded = {1'b0, sum_i};
        if (osr_i != '0) begin
            rounded = {1'b0, sum_i} + ((ACC_W+1)'(1) << (osr_i - OSR_W'(1)));
        end
    end
`else
    always_comb begin
        rounded = {1'b0, sum_i};
    end
`endif

    // The mean of DW-bit samples always fits in DW bits, so the upper bits
    // of the shifted value are zero and can be dropped.
    assign avg_o = DW'(rounded >> osr_i);

endmodule

// File: rtl/sar_avg_seq.sv
// sar_avg_seq
// Conversion sequencer and oversampling averager. A start request in IDLE
// enables the SAR, 2^osr results are summed and the shifted average is
// offered on a valid/ready port, once or continuously.
//   clk, rst   : clock, synchronous active-high reset
//   start      : burst request (IDLE only); cont/osr sampled with it
//   sar_valid  : SAR result strobe; sar_result : SAR result
//   sar_en     : SAR enable (high in RUN)
//   busy       : sequencer not idle
//   ovr        : sticky, a result arrived during OUT and was dropped
//   out_if     : averaged-result stream (master side)
// Build option: SAR_AVG_ROUND_EN selects rounding in sar_avg_shift.
module sar_avg_seq
    import sar_avg_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OSR_W = OSR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [OSR_W-1:0] osr,
    input  logic             sar_valid,
    input  logic [DW-1:0]    sar_result,
    output logic             sar_en,
    output logic             busy,
    output logic             ovr,
    sar_avg_seq_if.master    out_if
);
    localparam int ACC_W = acc_w(DW, OSR_W);
    localparam int CNT_W = (1 << OSR_W) - 1;

    sar_state_e       state_q, state_d;
    logic [OSR_W-1:0] osr_q, osr_d;
    logic             cont_q, cont_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             ovr_q, ovr_d;

    logic [ACC_W-1:0] sum_next;
    logic [DW-1:0]    avg_next;
    logic [CNT_W:0]   cnt_last;
    logic             is_last;

    // Sum including the sample on the bus, so the average is ready on the
    // same edge the last sample is taken.
    assign sum_next = acc_q + ACC_W'(sar_result);
    assign cnt_last = (((CNT_W+1)'(1)) << osr_q) - (CNT_W+1)'(1);
    assign is_last  = ({1'b0, cnt_q} == cnt_last);

    sar_avg_shift #(
        .DW    (DW),
        .OSR_W (OSR_W),
        .ACC_W (ACC_W)
    ) u_shift (
        .sum_i (sum_next),
        .osr_i (osr_q),
        .avg_o (avg_next)
    );

    always_comb begin
        state_d    = state_q;
        osr_d      = osr_q;
        cont_d     = cont_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        ovr_d      = ovr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    osr_d   = osr;
                    cont_d  = cont;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sar_valid) begin
                    acc_d = sum_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        out_data_d = avg_next;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                // The SAR is disabled here, so a late result is lost,
                // including one coinciding with a continuous-mode handshake.
                if (sar_valid) begin
                    ovr_d = 1'b1;
                end
                if (out_if.out_ready) begin
                    if (cont_q) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            osr_q      <= '0;
            cont_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            osr_q      <= osr_d;
            cont_q     <= cont_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            ovr_q      <= ovr_d;
        end
    end

    assign sar_en           = (state_q == RUN);
    assign busy             = (state_q != IDLE);
    assign ovr              = ovr_q;
    assign out_if.out_valid = (state_q == OUT);
    assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_sar_avg_seq.sv
// tb_sar_avg_seq
// Directed scenarios with literal expectations, then randomized traffic,
// all cross-checked every cycle against a sample-queue reference model.
module tb_sar_avg_seq;
    import sar_avg_pkg::*;

    localparam int DW    = DW_DEF;
    localparam int OSR_W = OSR_W_DEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cont;
    logic [OSR_W-1:0] osr;
    logic             sar_valid;
    logic [DW-1:0]    sar_result;
    logic             sar_en;
    logic             busy;
    logic             ovr;

    sar_avg_seq_if #(.DW(DW)) out_if ();

    sar_avg_seq #(.DW(DW), .OSR_W(OSR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .osr        (osr),
        .sar_valid  (sar_valid),
        .sar_result (sar_result),
        .sar_en     (sar_en),
        .busy       (busy),
        .ovr        (ovr),
        .out_if     (out_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase 0 = idle, 1 = collecting, 2 = holding result
    int          m_phase = 0;
    int unsigned m_q[$];
    int          m_osr   = 0;
    bit          m_cont  = 1'b0;
    bit          m_ovr   = 1'b0;
    int unsigned m_out   = 0;

    function automatic int unsigned model_avg(input int o);
        int unsigned s = 0;
        foreach (m_q[k]) s += m_q[k];
`ifdef SAR_AVG_ROUND_EN
        if (o > 0) s += (1 << (o - 1));
`endif
        return s >> o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_q.delete(); m_osr = 0; m_cont = 0; m_ovr = 0; m_out = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_osr = int'(osr); m_cont = cont; m_q.delete(); m_ovr = 0; m_phase = 1;
                end
                1: if (sar_valid) begin
                    m_q.push_back(int'(sar_result));
                    if (m_q.size() == (1 << m_osr)) begin
                        m_out   = model_avg(m_osr);
                        m_phase = 2;
                    end
                end
                default: begin
                    if (sar_valid) m_ovr = 1;
                    if (out_if.out_ready) begin
                        if (m_cont) begin
                            m_q.delete(); m_phase = 1;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",      32'(busy),             32'(m_phase != 0));
            check("cyc_sar_en",    32'(sar_en),           32'(m_phase == 1));
            check("cyc_out_valid", 32'(out_if.out_valid), 32'(m_phase == 2));
            check("cyc_out_data",  32'(out_if.out_data),  m_out);
            check("cyc_ovr",       32'(ovr),              32'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int o, input bit c);
        start = 1'b1; osr = OSR_W'(o); cont = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int v);
        sar_valid = 1'b1; sar_result = DW'(v);
        tick();
        sar_valid = 1'b0;
    endtask

    task automatic handshake();
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
    endtask

    initial begin
        int exp2;
        rst = 1'b1; start = 0; cont = 0; osr = '0; sar_valid = 0; sar_result = '0;
        out_if.out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_sar_en", 32'(sar_en), 0);
        check("rst_out_valid", 32'(out_if.out_valid), 0);
        check("rst_out_data", 32'(out_if.out_data), 0);
        check("rst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        tick();

        // osr=0 passes the raw sample straight through
        do_start(0, 0);
        check("t1_sar_en_rise", 32'(sar_en), 1);
        send(200);
        check("t1_sar_en_fall", 32'(sar_en), 0);
        check("t1_valid", 32'(out_if.out_valid), 1);
        check("t1_data", 32'(out_if.out_data), 200);
        check("t1_model", m_out, 200);
        handshake();
        check("t1_idle", 32'(busy), 0);
        $display("[TB] txn osr=0 sample=200 -> %0d", out_if.out_data);

        // osr=2, sum 46
`ifdef SAR_AVG_ROUND_EN
        exp2 = 12;
`else
        exp2 = 11;
`endif
        do_start(2, 0);
        send(10); send(11); send(12); send(13);
        check("t2_valid", 32'(out_if.out_valid), 1);
        check("t2_data", 32'(out_if.out_data), 32'(exp2));
        check("t2_model", m_out, 32'(exp2));
        handshake();
        $display("[TB] txn osr=2 samples 10..13 -> %0d", exp2);

        // osr=7, full-scale samples must not wrap
        do_start(7, 0);
        for (int i = 0; i < 128; i++) begin
            check("t3_busy", 32'(busy), 1);
            send(255);
        end
        check("t3_data", 32'(out_if.out_data), 255);
        check("t3_valid", 32'(out_if.out_valid), 1);
        handshake();
        $display("[TB] txn osr=7 128x255 -> 255");

        // continuous mode with a stalled consumer
        do_start(1, 1);
        send(7); send(9);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) sar_valid = 1'b1;
            tick();
            sar_valid = 1'b0;
            check("t4_hold", 32'(out_if.out_data), 8);
            check("t4_valid_hold", 32'(out_if.out_valid), 1);
        end
        check("t4_ovr", 32'(ovr), 1);
        handshake();
        check("t4_sar_en_again", 32'(sar_en), 1);
        check("t4_valid_drop", 32'(out_if.out_valid), 0);
        $display("[TB] txn cont osr=1 samples 7,9 -> 8, ovr=%0d", ovr);

        // reset mid-burst
        rst = 1'b1; tick(); rst = 1'b0;
        do_start(2, 0);
        send(50); send(60);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_sar_en", 32'(sar_en), 0);
        check("t5_valid", 32'(out_if.out_valid), 0);
        check("t5_data", 32'(out_if.out_data), 0);
        check("t5_ovr", 32'(ovr), 0);
        do_start(2, 0);
        send(4); send(4); send(4); send(4);
        check("t5_fresh", 32'(out_if.out_data), 4);
        handshake();
        $display("[TB] txn reset mid-run then 4x4 -> 4");

        // stray sar_valid in IDLE and start while busy
        send(99);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_valid", 32'(out_if.out_valid), 0);
        check("t6_idle_ovr", 32'(ovr), 0);
        do_start(1, 0);
        do_start(3, 1);
        send(3); send(5);
        check("t6_valid", 32'(out_if.out_valid), 1);
        check("t6_data", 32'(out_if.out_data), 4);
        handshake();
        check("t6_back_idle", 32'(busy), 0);
        check("t6_ovr", 32'(ovr), 0);
        $display("[TB] txn start-while-busy ignored -> 4");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst              = ($urandom_range(0, 149) == 0);
            start            = ($urandom_range(0, 5) == 0);
            cont             = ($urandom_range(0, 3) == 0);
            osr              = OSR_W'($urandom_range(0, 4));
            sar_valid        = ($urandom_range(0, 2) == 0);
            sar_result       = DW'($urandom);
            out_if.out_ready = $urandom_range(0, 1) == 1;
            tick();
            if (out_if.out_valid && out_if.out_ready)
                $display("[TB] txn random osr=%0d -> %0d", m_osr, out_if.out_data);
        end
        rst = 1'b1; start = 0; sar_valid = 0; out_if.out_ready = 0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
